// File: rtl/seq_detect_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_fsm
//  Brief    : Serial pattern detector. Shifts in one bit per enabled clock,
//             compares the most recent PAT_W bits against PATTERN and emits a
//             registered one-cycle match pulse (optional overlap). An optional
//             saturating hit counter is built when SEQ_DET_COUNT_EN is defined.
//  Config   : `define SEQ_DET_COUNT_EN  -> build the saturating hit counter
//  Revision : 1.0  initial release
// ============================================================================
module seq_detect_fsm #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         din,
    output logic                         match,
    output logic [$clog2(PAT_W+1)-1:0]   fill,
    output logic [CNT_W-1:0]             hit_count
);

    localparam int                FILL_W     = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] c_FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] c_FILL_ONE = FILL_W'(1);

    logic [PAT_W-1:0]  r_window;
    logic [FILL_W-1:0] r_fill;
    logic              r_match;

    logic [PAT_W-1:0]  w_window_n;
    logic [FILL_W-1:0] w_fill_n;
    logic              w_hit;

    // Candidate next window/fill and the hit decision for an accepted bit.
    // The fill qualifier stops the zero-initialised window from matching an
    // all-zero pattern before PAT_W real bits have arrived.
    always_comb begin
        w_window_n = (r_window << 1) | {{(PAT_W-1){1'b0}}, din};
        w_fill_n   = (r_fill == c_FILL_MAX) ? c_FILL_MAX : (r_fill + c_FILL_ONE);
        w_hit      = en && (w_fill_n == c_FILL_MAX) && (w_window_n == PATTERN);
    end

    // Window, fill and match registers; a hit without overlap restarts fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_window <= '0;
            r_fill   <= '0;
            r_match  <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (en) begin
                r_window <= w_window_n;
                r_fill   <= (w_hit && !OVERLAP) ? '0 : w_fill_n;
            end
        end
    end

    assign match = r_match;
    assign fill  = r_fill;

`ifdef SEQ_DET_COUNT_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_hit_count;

    // Saturating hit counter, updated on the same edge as match.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count <= '0;
        end else if (w_hit && (r_hit_count != c_CNT_MAX)) begin
            r_hit_count <= r_hit_count + c_CNT_ONE;
        end
    end

    assign hit_count = r_hit_count;
`else
    assign hit_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detect_fsm
//  Brief    : Directed self-checking bench for seq_detect_fsm. Four instances
//             share one stimulus: defaults, OVERLAP=0, PATTERN=0000, CNT_W=2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_detect_fsm;

`ifdef SEQ_DET_COUNT_EN
    localparam bit c_CNT_ON = 1'b1;
`else
    localparam bit c_CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic din = 1'b0;

    logic       ov_match,   no_match,   z_match,   c2_match;
    logic [2:0] ov_fill,    no_fill,    z_fill,    c2_fill;
    logic [7:0] ov_cnt,     no_cnt,     z_cnt;
    logic [1:0] c2_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_detect_fsm u_ov (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .match(ov_match), .fill(ov_fill), .hit_count(ov_cnt)
    );

    seq_detect_fsm #(.OVERLAP(1'b0)) u_no (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .match(no_match), .fill(no_fill), .hit_count(no_cnt)
    );

    seq_detect_fsm #(.PATTERN(4'b0000)) u_zero (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .match(z_match), .fill(z_fill), .hit_count(z_cnt)
    );

    seq_detect_fsm #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .match(c2_match), .fill(c2_fill), .hit_count(c2_cnt)
    );

    // Serial input must be known whenever it is sampled.
    always @(posedge clk) begin
        if (en === 1'b1 && rst === 1'b0) begin
            n_assert++;
            assert (!$isunknown(din)) else begin
                n_fail++;
                $error("FAIL din_known observed=%b expected=0/1", din);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one clock of stimulus, then sample just after the edge.
    task automatic drive(input logic r, input logic e, input logic b);
        @(negedge clk);
        rst = r;
        en  = e;
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
    endtask

    logic [6:0]  s1       = 7'b1011011;
    logic [6:0]  m1_ov    = 7'b0001001;
    logic [6:0]  m1_no    = 7'b0001000;
    int          f1_ov[7] = '{1, 2, 3, 4, 4, 4, 4};
    int          f1_no[7] = '{1, 2, 3, 0, 1, 2, 3};
    logic [15:0] s5       = 16'b1011011011011011;
    logic [15:0] m5       = 16'b0001001001001001;

    initial begin
        int exp_c2;
        int exp_ov;

        // ---- Test 1/2: overlap vs no-overlap on 1011011 -------------------
        do_reset(2);
        chk("rst_match", ov_match, 0);
        chk("rst_fill",  ov_fill,  0);
        chk("rst_cnt",   ov_cnt,   0);
        chk("rst_z_fill", z_fill,  0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, s1[6-i]);
            chk("t1_ov_match", ov_match, m1_ov[6-i]);
            chk("t1_ov_fill",  ov_fill,  f1_ov[i]);
            chk("t2_no_match", no_match, m1_no[6-i]);
            chk("t2_no_fill",  no_fill,  f1_no[i]);
            chk("t1_z_match",  z_match,  0);
        end
        chk("t1_ov_cnt", ov_cnt, c_CNT_ON ? 2 : 0);
        chk("t2_no_cnt", no_cnt, c_CNT_ON ? 1 : 0);
        drive(1'b0, 1'b0, 1'b1);
        chk("t1_idle_match", ov_match, 0);
        chk("t1_idle_fill",  ov_fill,  4);

        // ---- Test 3: reset mid-pattern (en/din held active during rst) ----
        do_reset(1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        chk("t3_pre_fill", ov_fill, 3);
        drive(1'b1, 1'b1, 1'b1);
        chk("t3_rst_fill",  ov_fill,  0);
        chk("t3_rst_match", ov_match, 0);
        drive(1'b0, 1'b1, 1'b1);
        chk("t3_b1_match", ov_match, 0);
        chk("t3_b1_fill",  ov_fill,  1);
        drive(1'b0, 1'b1, 1'b0);
        chk("t3_b2_match", ov_match, 0);
        drive(1'b0, 1'b1, 1'b1);
        chk("t3_b3_match", ov_match, 0);
        chk("t3_b3_fill",  ov_fill,  3);
        drive(1'b0, 1'b1, 1'b1);
        chk("t3_b4_match",    ov_match, 1);
        chk("t3_b4_no_match", no_match, 1);
        chk("t3_b4_no_fill",  no_fill,  0);

        // ---- Test 4: enable gap does not break the sequence --------------
        do_reset(1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            chk("t4_gap_match", ov_match, 0);
            chk("t4_gap_fill",  ov_fill,  2);
        end
        drive(1'b0, 1'b1, 1'b1);
        chk("t4_b3_match", ov_match, 0);
        chk("t4_b3_fill",  ov_fill,  3);
        drive(1'b0, 1'b1, 1'b1);
        chk("t4_b4_match", ov_match, 1);
        drive(1'b0, 1'b0, 1'b1);
        chk("t4_after_match", ov_match, 0);
        chk("t4_after_fill",  ov_fill,  4);

        // ---- Test 5: five overlapping matches, 2-bit saturating counter --
        do_reset(1);
        exp_c2 = 0;
        exp_ov = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, s5[15-i]);
            if (c_CNT_ON && m5[15-i]) begin
                if (exp_c2 < 3) exp_c2++;
                exp_ov++;
            end
            chk("t5_c2_match", c2_match, m5[15-i]);
            chk("t5_c2_cnt",   c2_cnt,   exp_c2);
        end
        chk("t5_c2_final", c2_cnt, c_CNT_ON ? 3 : 0);
        chk("t5_ov_final", ov_cnt, c_CNT_ON ? 5 : 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            chk("t5_c2_hold", c2_cnt, exp_c2);
        end

        // ---- Test 6: all-zero pattern needs a full window ----------------
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            chk("t6_early_match", z_match, 0);
            chk("t6_early_fill",  z_fill,  i + 1);
        end
        drive(1'b0, 1'b1, 1'b0);
        chk("t6_b4_match", z_match, 1);
        chk("t6_b4_fill",  z_fill,  4);
        drive(1'b0, 1'b1, 1'b0);
        chk("t6_b5_match", z_match, 1);
        drive(1'b0, 1'b1, 1'b1);
        chk("t6_b6_match", z_match, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
